polyt1_pack_stream: RTL and testbench

Serialises the high part t1 of a Dilithium public-key polynomial into the 320-byte packed t1 format. It is a byte stream with valid/ready handshake. It sits directly downstream of the poly_power2round stage: it captures that stage's 256×32-bit a1 bus in one cycle, then emits the encoding one byte per accepted transfer toward the public-key buffer / SHAKE absorber. Coefficients are packed 4 per 5 bytes, little-endian, 10 bits each, matching the reference polyt1_pack byte order.

---
 rtl/dilithium_pkg.sv | 11 +
 rtl/t1_byte_sel.sv | 11 +
 rtl/polyt1_pack_stream.sv | 72 +++++++
 tb/tb_polyt1_pack_stream.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dilithium_pkg.sv
// dilithium_pkg: shared Dilithium constants and the t1 packer FSM state type
package dilithium_pkg;
  localparam int N          = 256;
  localparam int T1_BITS    = 10;
  localparam int D          = 13;
  localparam int PACK_BYTES = 320;
  localparam int GROUP_BITS = 40;
  localparam int SUB_LAST   = 4;
  localparam int GRP_LAST   = 63;
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
endpackage

// File: rtl/t1_byte_sel.sv
// t1_byte_sel: pick byte i_sub of a packed group word (i_word, i_sub -> o_byte)
module t1_byte_sel #(
  parameter int GW = 40,
  parameter int SW = 3
) (
  input  logic [GW-1:0] i_word,
  input  logic [SW-1:0] i_sub,
  output logic [7:0]    o_byte
);
  assign o_byte = 8'(i_word >> {i_sub, 3'b000});
endmodule

// File: rtl/polyt1_pack_stream.sv
// polyt1_pack_stream: capture 256x32-bit t1 in one cycle, stream 320 packed bytes
// ports: i_clk, i_rst_n (async low), i_start capture; i_t1_in coefficient bus;
// o_busy/o_done status, o_range_err sticky high-bit flag; o_byte_* valid/ready byte stream
module polyt1_pack_stream
  import dilithium_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [N*32-1:0]  i_t1_in,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_range_err,
  output logic [7:0]       o_byte_out,
  output logic             o_byte_valid,
  input  logic             i_byte_ready
);
  logic [N*T1_BITS-1:0] r_sr;
  logic [N*T1_BITS-1:0] w_cap;
  logic [N-1:0]         w_hi;
  state_t               r_state;
  state_t               w_next;
  logic [5:0]           r_grp;
  logic [2:0]           r_sub;
  logic                 r_err;
  logic                 w_xfer;
  logic                 w_last;
  for (genvar i = 0; i < N; i++) begin : g_cap
    assign w_cap[T1_BITS*i +: T1_BITS] = i_t1_in[32*i +: T1_BITS];
    assign w_hi[i] = |i_t1_in[32*i+T1_BITS +: 32-T1_BITS];
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_grp   <= '0;
      r_sub   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && i_start) begin
        r_sr  <= w_cap;
        r_err <= |w_hi;
        r_grp <= '0;
        r_sub <= '0;
      end else if (w_xfer) begin
        if (r_sub == 3'(SUB_LAST)) begin
          r_sub <= '0;
          r_grp <= r_grp + 6'd1;
          r_sr  <= {{GROUP_BITS{1'b0}}, r_sr[N*T1_BITS-1:GROUP_BITS]};
        end else begin
          r_sub <= r_sub + 3'd1;
        end
      end
    end
  end
  always_comb begin
    w_xfer       = (r_state == EMIT) && i_byte_ready;
    w_last       = w_xfer && r_grp == 6'(GRP_LAST) && r_sub == 3'(SUB_LAST);
    w_next       = r_state == IDLE ? (i_start ? EMIT : IDLE) :
                   r_state == EMIT ? (w_last ? DONE : EMIT) : IDLE;
    o_busy       = r_state == EMIT;
    o_byte_valid = r_state == EMIT;
    o_done       = r_state == DONE;
    o_range_err  = r_err;
  end
  t1_byte_sel #(.GW(GROUP_BITS), .SW(3)) u_sel (
    .i_word (r_sr[GROUP_BITS-1:0]),
    .i_sub  (r_sub),
    .o_byte (o_byte_out)
  );
endmodule

// File: tb/tb_polyt1_pack_stream.sv
// tb_polyt1_pack_stream: directed self-checking bench for the t1 byte packer
module tb_polyt1_pack_stream;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [8191:0] t1_in = '0;
  logic          busy, done, range_err, byte_valid;
  logic [7:0]    byte_out;
  logic          byte_ready = 1'b0;
  int            checks = 0;
  int            failures = 0;
  logic [9:0]    exp_c [256];
  logic [7:0]    got_b [320];

  always #5 clk = ~clk;

  polyt1_pack_stream dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_t1_in      (t1_in),
    .o_busy       (busy),
    .o_done       (done),
    .o_range_err  (range_err),
    .o_byte_out   (byte_out),
    .o_byte_valid (byte_valid),
    .i_byte_ready (byte_ready)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input int k);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = exp_c[(8*k+j)/10][(8*k+j)%10];
    return r;
  endfunction

  task automatic set_coef(input int i, input logic [31:0] v);
    t1_in[32*i +: 32] = v;
    exp_c[i] = v[9:0];
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < 256; i++) set_coef(i, kind == 1 ? 32'(i % 1024) : 32'd0);
  endtask

  task automatic cap();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input bit rnd, input int pulse_at, input int abort_at, input int exp_err);
    int n = 0;
    int cyc = 1;
    bit stalled = 1'b0;
    logic [7:0] prev = '0;
    cap();
    chk("busy_c1", 32'(busy), 1);
    chk("range_err_c1", 32'(range_err), exp_err);
    while (n < 320 && cyc < 5000) begin
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(byte_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(range_err), 0);
        chk("rst_byte", 32'(byte_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (!byte_valid || done) chk("valid_in_emit", 32'({byte_valid, done}), 2);
      if (stalled) chk("stall_stable", 32'(byte_out), 32'(prev));
      byte_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
      start = (n == pulse_at);
      if (n == pulse_at) t1_in = '1;
      prev = byte_out;
      stalled = !byte_ready;
      if (byte_ready) begin
        got_b[n] = byte_out;
        chk($sformatf("byte%0d", n), 32'(byte_out), 32'(model_byte(n)));
        n++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    if (cyc >= 5000) chk("stream_timeout", cyc, 0);
    byte_ready = 1'b0;
    chk("done_pulse", 32'(done), 1);
    chk("busy_at_done", 32'(busy), 0);
    chk("valid_at_done", 32'(byte_valid), 0);
    if (!rnd) chk("done_cycle", cyc, 321);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_valid", 32'(byte_valid), 0);
  endtask

  initial begin
    fill(0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_valid", 32'(byte_valid), 0);
    chk("reset_err", 32'(range_err), 0);
    chk("reset_byte", 32'(byte_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_start", 32'(busy), 0);
    run(0, -1, -1, 0);
    fill(0);
    set_coef(0, 32'h3FF);
    run(0, -1, -1, 0);
    chk("c0max_b0", 32'(got_b[0]), 32'hFF);
    chk("c0max_b1", 32'(got_b[1]), 32'h03);
    chk("c0max_b2", 32'(got_b[2]), 32'h00);
    fill(1);
    run(0, -1, -1, 0);
    chk("ramp_b0", 32'(got_b[0]), 32'h00);
    chk("ramp_b1", 32'(got_b[1]), 32'h04);
    chk("ramp_b2", 32'(got_b[2]), 32'h20);
    chk("ramp_b3", 32'(got_b[3]), 32'hC0);
    chk("ramp_b4", 32'(got_b[4]), 32'h00);
    chk("ramp_b315", 32'(got_b[315]), 32'hFC);
    chk("ramp_b319", 32'(got_b[319]), 32'h3F);
    fill(1);
    run(1, -1, -1, 0);
    chk("rnd_b3", 32'(got_b[3]), 32'hC0);
    fill(1);
    t1_in[32*5 +: 32] = 32'h0000_0400;
    exp_c[5] = 10'd0;
    run(0, -1, -1, 1);
    chk("err_b6", 32'(got_b[6]), 32'h00);
    chk("err_hold", 32'(range_err), 1);
    fill(1);
    run(0, -1, -1, 0);
    fill(1);
    run(1, 50, -1, 0);
    fill(1);
    t1_in[32*7 +: 32] = 32'h8000_0007;
    run(0, -1, 100, 1);
    chk("post_rst_idle", 32'(busy), 0);
    fill(1);
    run(0, -1, -1, 0);
    chk("fresh_b1", 32'(got_b[1]), 32'h04);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
